// File: rtl/yf_imem_arbiter.sv
// rtl/yf_imem_arbiter.sv - instruction memory arbiter between CPU fetch and loader/debug port
module yf_imem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  // CPU fetch port (read-only)
  input  logic          c_req,
  input  logic [AW-1:0] c_addr,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  // loader / host debug port
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  input  logic          l_lock,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  // single-port memory
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {
    ST_RR   = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_t     state_q, state_d;
  logic       last_win_q, last_win_d;   // 1: loader won the last grant
  logic [7:0] burst_cnt_q, burst_cnt_d;

  // Grant selection and next arbitration state; nothing is granted during reset
  always_comb begin
    c_gnt       = 1'b0;
    l_gnt       = 1'b0;
    state_d     = state_q;
    last_win_d  = last_win_q;
    burst_cnt_d = burst_cnt_q;
    if (!rst) begin
      if (state_q == ST_LOCK && l_lock) begin
        // Locked burst: loader keeps the port until the burst limit is hit
        // while the CPU is waiting, then the CPU gets exactly one slot.
        if (l_req && (burst_cnt_q < BURST_MAX || !c_req)) begin
          l_gnt = 1'b1;
          if (burst_cnt_q < BURST_MAX) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
        end else if (c_req) begin
          c_gnt = 1'b1;
          if (l_req) begin
            burst_cnt_d = 8'd0;
          end
        end
      end else begin
        // Round-robin; a dropped lock falls through here in the same cycle
        state_d     = ST_RR;
        burst_cnt_d = 8'd0;
        if (c_req && l_req) begin
          if (last_win_q) begin
            c_gnt = 1'b1;
          end else begin
            l_gnt = 1'b1;
          end
        end else begin
          c_gnt = c_req;
          l_gnt = l_req;
        end
        if (l_gnt && l_lock) begin
          state_d     = ST_LOCK;
          burst_cnt_d = 8'd1;
        end
      end
      if (c_gnt) begin
        last_win_d = 1'b0;
      end else if (l_gnt) begin
        last_win_d = 1'b1;
      end
    end
  end

  // Memory request mux; the CPU side never writes
  always_comb begin
    mem_en    = c_gnt | l_gnt;
    mem_we    = l_gnt & l_we;
    mem_addr  = l_gnt ? l_addr : c_addr;
    mem_wdata = l_wdata;
  end

  // Read data follows the memory directly; rvalid qualifies the owner
  always_comb begin
    c_rdata = mem_rdata;
    l_rdata = mem_rdata;
  end

  // Arbitration state and one-cycle read-return tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RR;
      last_win_q  <= 1'b1;
      burst_cnt_q <= 8'd0;
      c_rvalid    <= 1'b0;
      l_rvalid    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_win_q  <= last_win_d;
      burst_cnt_q <= burst_cnt_d;
      c_rvalid    <= c_gnt;
      l_rvalid    <= l_gnt & ~l_we;
    end
  end

endmodule

// File: tb/tb_yf_imem_arbiter.sv
// tb/tb_yf_imem_arbiter.sv - scoreboard bench for yf_imem_arbiter
module tb_yf_imem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MB = 4;

  localparam byte GC = 8'h43;  // 'C'
  localparam byte GL = 8'h4C;  // 'L'
  localparam byte GN = 8'h2E;  // '.'
  localparam byte GX = 8'h58;  // 'X' both granted

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_gnt, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_rdata;
  logic          l_req, l_we, l_lock, l_gnt, l_rvalid;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata, l_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  yf_imem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_addr(c_addr), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Single-port synchronous memory with a preload path used while in reset
  logic [DW-1:0] mem [0:63];
  logic          pl_we;
  logic [5:0]    pl_addr;
  logic [DW-1:0] pl_data;
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    byte           g;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gent_t;
  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } rent_t;

  gent_t         g_q[$];
  rent_t         c_q[$];
  rent_t         l_q[$];
  byte           pat[int];
  logic [DW-1:0] ref_mem [0:63];
  int            checks = 0;
  int            failures = 0;
  bit            mon_on = 0;
  bit            done = 0;
  bit            drained = 0;
  int            last_cyc = 0;

  // Reference model state: lock held, loader grants in current burst, who won last
  bit m_locked;
  int m_cnt;
  bit m_last_l;

  // Drive one cycle, let the reference decide the winner, queue expectations
  task automatic step(input logic r, input logic cr, input logic [AW-1:0] ca,
                      input logic lr, input logic lwe, input logic [AW-1:0] la,
                      input logic [DW-1:0] lw, input logic ll, output byte win);
    gent_t e;
    rent_t re;
    @(posedge clk);
    #1;
    rst = r; c_req = cr; c_addr = ca; l_req = lr; l_we = lwe;
    l_addr = la; l_wdata = lw; l_lock = ll;
    win = GN;
    if (r) begin
      m_locked = 0; m_cnt = 0; m_last_l = 1;
    end else begin
      if (m_locked && ll) begin
        if (lr && (m_cnt < MB || !cr)) begin
          win = GL;
          if (m_cnt < MB) m_cnt = m_cnt + 1;
        end else if (cr) begin
          win = GC;
          if (lr) m_cnt = 0;
        end
      end else begin
        m_locked = 0; m_cnt = 0;
        if (cr && lr) win = m_last_l ? GC : GL;
        else if (cr)  win = GC;
        else if (lr)  win = GL;
        if (win == GL && ll) begin
          m_locked = 1; m_cnt = 1;
        end
      end
      if (win == GC) m_last_l = 0;
      else if (win == GL) m_last_l = 1;
    end
    e.cyc = cyc; e.g = win; e.we = (win == GL) && lwe;
    e.addr = (win == GL) ? la : ca; e.wdata = lw;
    g_q.push_back(e);
    re.cyc = cyc + 1;
    if (win == GC) begin
      re.data = ref_mem[ca[5:0]];
      c_q.push_back(re);
    end else if (win == GL) begin
      if (lwe) ref_mem[la[5:0]] = lw;
      else begin
        re.data = ref_mem[la[5:0]];
        l_q.push_back(re);
      end
    end
    last_cyc = cyc;
  endtask

  task automatic idle();
    byte w;
    step(0, 0, 0, 0, 0, 0, 0, 0, w);
  endtask

  // Expected literal grant sequence for the upcoming cycles
  task automatic expect_pattern(input string s);
    for (int i = 0; i < s.len(); i++) pat[last_cyc + 1 + i] = s[i];
  endtask

  // Monitor: compares grants every cycle, pops read returns when rvalid shows
  always @(negedge clk) begin
    gent_t e;
    rent_t r;
    byte   got;
    bit    exp_c, exp_l;
    if (g_q.size() > 0) begin
      e = g_q.pop_front();
      got = (c_gnt && l_gnt) ? GX : c_gnt ? GC : l_gnt ? GL : GN;
      checks++;
      if (got != e.g || mem_en != (e.g != GN) || mem_we != e.we) begin
        failures++;
        $display("FAIL grant cyc=%0d got=%c en=%b we=%b expected=%c we=%b",
                 e.cyc, got, mem_en, mem_we, e.g, e.we);
      end
      if (e.g != GN) begin
        checks++;
        if (mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
          failures++;
          $display("FAIL mem_bus cyc=%0d addr=%h wdata=%h expected addr=%h wdata=%h",
                   e.cyc, mem_addr, mem_wdata, e.addr, e.wdata);
        end
      end
      if (pat.exists(e.cyc)) begin
        checks++;
        if (got != pat[e.cyc]) begin
          failures++;
          $display("FAIL pattern cyc=%0d got=%c expected=%c", e.cyc, got, pat[e.cyc]);
        end
      end
    end
    if (mon_on) begin
      exp_c = (c_q.size() > 0) && (c_q[0].cyc == cyc);
      exp_l = (l_q.size() > 0) && (l_q[0].cyc == cyc);
      checks++;
      if (c_rvalid !== exp_c) begin
        failures++;
        $display("FAIL c_rvalid cyc=%0d got=%b expected=%b", cyc, c_rvalid, exp_c);
      end
      if (exp_c) begin
        r = c_q.pop_front();
        checks++;
        if (c_rdata !== r.data) begin
          failures++;
          $display("FAIL c_rdata cyc=%0d got=%h expected=%h", cyc, c_rdata, r.data);
        end
      end
      checks++;
      if (l_rvalid !== exp_l) begin
        failures++;
        $display("FAIL l_rvalid cyc=%0d got=%b expected=%b", cyc, l_rvalid, exp_l);
      end
      if (exp_l) begin
        r = l_q.pop_front();
        checks++;
        if (l_rdata !== r.data) begin
          failures++;
          $display("FAIL l_rdata cyc=%0d got=%h expected=%h", cyc, l_rdata, r.data);
        end
      end
      // drop any return that should already have appeared
      if (c_q.size() > 0 && c_q[0].cyc <= cyc) void'(c_q.pop_front());
      if (l_q.size() > 0 && l_q[0].cyc <= cyc) void'(l_q.pop_front());
    end
    if (done && !drained) begin
      drained = 1;
      checks++;
      if (g_q.size() != 0 || c_q.size() != 0 || l_q.size() != 0) begin
        failures++;
        $display("FAIL drain pending g=%0d c=%0d l=%0d expected 0", g_q.size(), c_q.size(), l_q.size());
      end
    end
  end

  initial begin
    byte           w;
    logic [DW-1:0] v;
    logic          cr, lr, lwe, ll, r;
    logic [AW-1:0] ca, la;
    logic [DW-1:0] lw;

    rst = 1; c_req = 0; c_addr = 0; l_req = 0; l_we = 0; l_addr = 0;
    l_wdata = 0; l_lock = 0; pl_we = 0; pl_addr = 0; pl_data = 0;
    m_locked = 0; m_cnt = 0; m_last_l = 1;

    // preload memory while held in reset
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      v = (i == 0) ? 16'h1000 : (i == 1) ? 16'h4D0D : (i == 2) ? 16'h10F2 : 16'($urandom);
      pl_we = 1; pl_addr = 6'(i); pl_data = v; ref_mem[i] = v;
    end
    @(posedge clk);
    #1;
    pl_we = 0;

    // requests during reset must not be granted
    step(1, 1, 0, 1, 0, 3, 0, 1, w);
    step(1, 1, 0, 1, 0, 3, 0, 1, w);
    mon_on = 1;

    // CPU-only fetches of the preloaded words
    expect_pattern("CCC");
    for (int i = 0; i < 3; i++) step(0, 1, 16'(i), 0, 0, 0, 0, 0, w);
    idle(); idle();

    // both requesting reads right out of reset: CPU wins first, then alternate
    step(1, 0, 0, 0, 0, 0, 0, 0, w);
    expect_pattern("CLCLCL");
    for (int i = 0; i < 6; i++) step(0, 1, 16'(i), 1, 0, 16'(3 + i), 0, 0, w);
    idle();

    // loader write followed by CPU read of the same word
    step(0, 0, 0, 1, 1, 5, 16'hABCD, 0, w);
    step(0, 1, 5, 0, 0, 0, 0, 0, w);
    idle(); idle();

    // locked write burst with CPU waiting throughout (last winner was CPU)
    expect_pattern("LLLLCLLLLCLL");
    for (int i = 0; i < 12; i++) step(0, 1, 7, 1, 1, 16'(8 + i), 16'($urandom), 1, w);
    idle();

    // locked burst with no CPU traffic, then CPU arrives, then lock drops
    expect_pattern("LLLLLLCL");
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 16'(20 + i), 16'($urandom), 1, w);
    step(0, 1, 9, 1, 1, 26, 16'h5A5A, 1, w);
    step(0, 1, 9, 1, 1, 26, 16'h5A5A, 0, w);
    idle();

    // reset in the middle of a locked read-back
    expect_pattern("LL.C");
    step(0, 0, 0, 1, 0, 10, 0, 1, w);
    step(0, 0, 0, 1, 0, 11, 0, 1, w);
    step(1, 1, 4, 1, 0, 12, 0, 1, w);
    step(0, 1, 4, 1, 0, 12, 0, 1, w);
    idle();

    // randomized traffic with held requests, lock toggling and rare resets
    cr = 0; lr = 0; ca = 0; la = 0; lw = 0; lwe = 0; ll = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!cr && $urandom_range(0, 2) != 0) begin
        cr = 1; ca = 16'($urandom_range(0, 63));
      end
      if (!lr && $urandom_range(0, 2) == 0) begin
        lr = 1; lwe = 1'($urandom_range(0, 1));
        la = 16'($urandom_range(0, 63)); lw = 16'($urandom);
      end
      if ($urandom_range(0, 7) == 0) ll = ~ll;
      r = ($urandom_range(0, 199) == 0);
      step(r, cr, ca, lr, lwe, la, lw, ll, w);
      if (w == GC) cr = 0;
      if (w == GL) lr = 0;
    end

    idle(); idle(); idle();
    done = 1;
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/yf_imem_arbiter.md
Name: yf_imem_arbiter

Overview:
- Shares the single-port instruction memory between two requesters.
- Requester 0 is the CPU fetch path; it is read-only.
- Requester 1 is the program loader or host debug port; it can read and write. It replaces the $readmemh-only load path so programs can be reloaded at run time.
- Arbitration is round-robin, plus a loader lock mode for uninterrupted burst writes. The lock is bounded by a burst limit so CPU fetch is never starved.

Parameters:
- AW, 16, memory address width (word address).
- DW, 16, memory data width (instruction word width).
- MAX_BURST, 8, maximum consecutive locked loader grants before one pending CPU request must be served. Range is 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- c_req  in  1  CPU fetch request; held until c_gnt
- c_addr  in  AW  CPU fetch address
- c_gnt  out  1  CPU request accepted this cycle (combinational)
- c_rvalid  out  1  c_rdata valid (registered)
- c_rdata  out  DW  fetched instruction word
- l_req  in  1  loader request; held until l_gnt
- l_we  in  1  loader write (1) or read (0)
- l_addr  in  AW  loader address
- l_wdata  in  DW  loader write data
- l_lock  in  1  loader requests burst lock
- l_gnt  out  1  loader request accepted this cycle (combinational)
- l_rvalid  out  1  l_rdata valid (registered; reads only)
- l_rdata  out  DW  loader read data
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid the cycle after a read is enabled

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=RR, last_win=LOADER (CPU wins the first tie), burst_cnt=0.
  - c_rvalid=0, l_rvalid=0.
  - While rst is high: c_gnt=0, l_gnt=0, mem_en=0, mem_we=0.
  - A read issued in the cycle reset is asserted produces no rvalid.
- Grants:
  - At most one grant per cycle; grants are combinational from req and state.
  - mem_en = c_gnt | l_gnt.
  - mem_addr and mem_wdata mux from the granted requester.
  - mem_we = l_gnt & l_we; the CPU never writes.
  - When nothing is granted, mem_addr and mem_wdata are don't-care.
- Read return:
  - 1-cycle latency. A read granted in cycle N gives rvalid=1 for exactly cycle N+1, to the requester granted in cycle N, with rdata = mem_rdata.
  - Writes produce no rvalid.
  - Back-to-back grants are allowed every cycle; returns are in order.
  - c_rdata and l_rdata may both follow mem_rdata; only the rvalid lines qualify them.
- State RR:
  - Only one requester asserting: it is granted.
  - Both asserting: the requester != last_win is granted.
  - last_win updates on every grant.
  - A loader grant with l_lock=1 moves state to LOCK and sets burst_cnt=1.
- State LOCK:
  - l_req=1 and (burst_cnt<MAX_BURST or c_req=0):
    - Loader is granted, burst_cnt increments, saturating at MAX_BURST.
  - l_req=1, burst_cnt==MAX_BURST and c_req=1:
    - The CPU is granted once.
    - burst_cnt returns to 0 and the state stays LOCK.
    - The next loader grant sets burst_cnt=1.
  - l_req=0 with c_req=1: CPU is granted; the state stays LOCK while l_lock=1.
  - l_lock=0 sampled in any LOCK cycle:
    - state returns to RR and burst_cnt=0.
    - That same cycle is arbitrated by the RR rules.
- Boundaries:
  - A request held without a grant must keep addr, we and wdata stable.
  - Simultaneous loader write and CPU read of the same address:
    - Only one is granted.
    - If the write is granted first, the CPU's later read returns the new data.
  - l_lock with l_we=0 is legal (locked read-back).
  - Reset during LOCK discards the burst.
- Implementation: one always block for registered state, plus combinational grant and mux logic.

Test Plan:
- Only c_req=1, addrs 0,1,2 on consecutive cycles, memory preloaded 0x1000/0x4D0D/0x10F2:
  - c_gnt=1 in each of the 3 cycles.
  - c_rvalid high cycles 2..4 with those words in order.
- c_req and l_req both held high (l_we=0) from reset for 6 cycles:
  - Grants go C,L,C,L,C,L.
  - Each rvalid goes only to the previous cycle's winner.
- Loader write 0xABCD to addr 5, then CPU reads addr 5 in the next cycle:
  - mem_we=1 only in the write cycle.
  - c_rdata=0xABCD with c_rvalid one cycle after the CPU grant.
- MAX_BURST=4, l_lock=1, l_we=1, l_req=1 for 12 cycles, c_req=1 throughout:
  - Grant pattern is L,L,L,L,C,L,L,L,L,C,L,L.
  - Exactly one CPU grant after each 4 loader grants.
- MAX_BURST=4, locked burst of 6 writes with c_req=0:
  - 6 consecutive l_gnt.
  - Raise c_req at burst 6: CPU is granted next cycle; drop l_lock: RR resumes.
- Assert rst for 1 cycle in the middle of a locked burst, with a read granted the cycle before:
  - Both rvalid outputs low the cycle after the rst edge; no grants while rst=1.
  - The next simultaneous request is granted to the CPU.
